// File: rtl/counter_4bit.sv
// Up/down modulo counter with synchronous active-low reset.
// Output is the count register itself; no combinational path from inputs.
module counter_4bit #(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 16,
    parameter int RESET_VALUE = 0
) (
    input  logic             clock_signal,
    input  logic             reset_signal,
    input  logic             up_down,
    output logic [WIDTH-1:0] output_wire
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_mod
            $error("counter_4bit: MODULUS must be in 2..2**WIDTH");
        end
        if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_rst
            $error("counter_4bit: RESET_VALUE must be below MODULUS");
        end
    endgenerate

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: explicit wrap at both ends so a non-power-of-two
    // modulus never lets the register leave 0..MODULUS-1.
    always_comb begin
        count_d = count_q;
        unique case (1'b1)
            up_down:  count_d = (count_q == TOP) ? '0 : count_q + ONE;
            !up_down: count_d = (count_q == '0) ? TOP : count_q - ONE;
        endcase
    end

    // Count register; reset is sampled only on the rising edge.
    always_ff @(posedge clock_signal) begin
        if (!reset_signal) begin
            count_q <= RST;
        end else begin
            count_q <= count_d;
        end
    end

    assign output_wire = count_q;

endmodule

// File: tb/tb_counter_4bit.sv
// Directed bench for counter_4bit: default instance plus a
// MODULUS=10, RESET_VALUE=3 instance.
module tb_counter_4bit;

    logic       clk;
    logic       rst_a;
    logic       up_a;
    logic [3:0] cnt_a;
    logic       rst_b;
    logic       up_b;
    logic [3:0] cnt_b;

    int errors = 0;
    int checks = 0;

    counter_4bit dut_a (
        .clock_signal(clk),
        .reset_signal(rst_a),
        .up_down     (up_a),
        .output_wire (cnt_a)
    );

    counter_4bit #(
        .WIDTH      (4),
        .MODULUS    (10),
        .RESET_VALUE(3)
    ) dut_b (
        .clock_signal(clk),
        .reset_signal(rst_b),
        .up_down     (up_b),
        .output_wire (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b0;
        up_a  = 1'b1;
        rst_b = 1'b0;
        up_b  = 1'b1;
        #2;

        // Reset held low for two edges.
        step();
        chk("a_reset1", cnt_a, 4'd0);
        step();
        chk("a_reset2", cnt_a, 4'd0);

        // Count up through the wrap: 1..15,0,1,2.
        rst_a = 1'b1;
        up_a  = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step();
            chk($sformatf("a_up%0d", i), cnt_a, 4'(i % 16));
        end

        // Back to 0, then count down through the wrap.
        rst_a = 1'b0;
        step();
        chk("a_rst_dn", cnt_a, 4'd0);
        rst_a = 1'b1;
        up_a  = 1'b0;
        step();
        chk("a_dn15", cnt_a, 4'd15);
        step();
        chk("a_dn14", cnt_a, 4'd14);
        step();
        chk("a_dn13", cnt_a, 4'd13);

        // Direction change around 5.
        rst_a = 1'b0;
        step();
        chk("a_rst_dir", cnt_a, 4'd0);
        rst_a = 1'b1;
        up_a  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("a_to5_%0d", i), cnt_a, 4'(i));
        end
        up_a = 1'b0;
        step();
        chk("a_dir_dn4", cnt_a, 4'd4);
        step();
        chk("a_dir_dn3", cnt_a, 4'd3);
        up_a = 1'b1;
        step();
        chk("a_dir_up4", cnt_a, 4'd4);
        step();
        chk("a_dir_up5", cnt_a, 4'd5);

        // Inputs toggled between edges have no effect.
        up_a = 1'b0;
        #2;
        up_a = 1'b1;
        step();
        chk("a_glitch6", cnt_a, 4'd6);

        // Reset mid-count at 9.
        step();
        chk("a_mid7", cnt_a, 4'd7);
        step();
        chk("a_mid8", cnt_a, 4'd8);
        step();
        chk("a_mid9", cnt_a, 4'd9);
        rst_a = 1'b0;
        step();
        chk("a_mid_rst", cnt_a, 4'd0);
        rst_a = 1'b1;
        step();
        chk("a_resume1", cnt_a, 4'd1);

        // Non-default instance: reset value 3, wrap at 9.
        chk("b_reset", cnt_b, 4'd3);
        rst_b = 1'b1;
        up_b  = 1'b1;
        for (int i = 4; i <= 10; i++) begin
            step();
            chk($sformatf("b_up%0d", i), cnt_b, 4'(i % 10));
        end
        up_b = 1'b0;
        step();
        chk("b_dn9", cnt_b, 4'd9);
        step();
        chk("b_dn8", cnt_b, 4'd8);
        rst_b = 1'b0;
        step();
        chk("b_rst_again", cnt_b, 4'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
